// File: rtl/pipelined_fp_accum_if.sv
// Handshake and data bundle between the dot-product controller and the accumulator.
// Latency: none, wires only.
// Backpressure: none. The producer paces products with in_valid, and the consumer reads done/out.
// master: drives go/len/in/in_valid and observes out/done/busy/overflow. slave: the accumulator side.
interface pipelined_fp_accum_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
);
  logic                        go;
  logic        [CNT_WIDTH-1:0] len;
  logic signed [WIDTH-1:0]     in;
  logic                        in_valid;
  logic signed [WIDTH-1:0]     out;
  logic                        done;
  logic                        busy;
  logic                        overflow;

  modport master (
    output go, len, in, in_valid,
    input  out, done, busy, overflow
  );

  modport slave (
    input  go, len, in, in_valid,
    output out, done, busy, overflow
  );
endinterface

// File: rtl/pipelined_fp_accum.sv
// Saturating signed fixed-point accumulator that sums len products behind the multiplier.
// Latency: products are absorbed in their arrival cycle, and done pulses the cycle after the last one.
// Backpressure: none. in_valid=0 cycles are stalls, and go is honoured only while idle.
// Ports: clk and reset (synchronous, active-high) are plain ports.
//        bus (slave modport) carries go/len/in/in_valid in and out/done/busy/overflow out.
module pipelined_fp_accum #(
  parameter int WIDTH      = 32,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  pipelined_fp_accum_if.slave  bus
);

  // The arithmetic does not depend on where the binary point sits.
  // The split only has to add up to WIDTH.
  if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_fmt_check
    $error("INT_WIDTH + FRAC_WIDTH must equal WIDTH");
  end

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t                      state, state_nxt;
  logic signed [WIDTH-1:0]     acc, acc_nxt;
  logic        [CNT_WIDTH-1:0] count, count_nxt;
  logic        [CNT_WIDTH-1:0] len_q, len_q_nxt;
  logic                        ovf, ovf_nxt;

  logic signed [WIDTH:0]       sum;
  logic signed [WIDTH-1:0]     sat_val;
  logic                        sat_hit;

  // A sign-extended sum whose top two bits disagree has left the WIDTH-bit range.
  // The top bit then gives the direction to clamp.
  always_comb begin
    sum     = {acc[WIDTH-1], acc} + {bus.in[WIDTH-1], bus.in};
    sat_hit = (sum[WIDTH] != sum[WIDTH-1]);
    sat_val = sum[WIDTH-1:0];
    if (sat_hit) begin
      sat_val = sum[WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      len_q <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      len_q <= len_q_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    len_q_nxt = len_q;
    ovf_nxt   = ovf;
    unique case (state)
      IDLE: begin
        if (bus.go) begin
          len_q_nxt = bus.len;
          acc_nxt   = '0;
          count_nxt = '0;
          ovf_nxt   = 1'b0;
          // An empty run skips ACC entirely and reports the cleared sum.
          state_nxt = (bus.len == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (bus.in_valid) begin
          acc_nxt   = sat_val;
          count_nxt = count + 1'b1;
          if (sat_hit) begin
            ovf_nxt = 1'b1;
          end
          // len_q is at least 1 here, so len_q-1 cannot underflow.
          // count stops at len_q-1 and never wraps.
          if (count == len_q - 1'b1) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // out tracks acc at all times. Partial sums are visible mid-run, and the final sum holds through IDLE.
  assign bus.out      = acc;
  assign bus.done     = (state == DONE);
  assign bus.busy     = (state != IDLE);
  assign bus.overflow = ovf;

endmodule

// File: tb/tb_pipelined_fp_accum.sv
module tb_pipelined_fp_accum;

  logic clk;
  logic reset;

  pipelined_fp_accum_if #(.WIDTH(32), .CNT_WIDTH(8)) bus ();

  pipelined_fp_accum #(
    .WIDTH(32), .INT_WIDTH(16), .FRAC_WIDTH(16), .CNT_WIDTH(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;

  // Advance one clock and settle just after the edge. Inputs and outputs are handled here.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.done === 1'b1) done_cnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    bus.in_valid = v;
    bus.in       = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic start(input logic [7:0] n, input logic [31:0] res, input logic ovf);
    exp_t e;
    e.res = res;
    e.ovf = ovf;
    sb.push_back(e);
    bus.go  = 1'b1;
    bus.len = n;
    tick();
    bus.go  = 1'b0;
  endtask

  // done must be high right now, which is the cycle after the last product. It must then drop.
  task automatic expect_done(input string tag);
    exp_t e;
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_out"}, bus.out, e.res);
      chk({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, e.ovf});
    end
    tick();
    chk({tag, "_done_drop"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_idle"},      {31'd0, bus.busy}, 32'd0);
  endtask

  int d0;

  initial begin
    reset = 1'b1;
    bus.go = 1'b0;
    bus.len = '0;
    bus.in = '0;
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("rst_out",  bus.out, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_ovf",  {31'd0, bus.overflow}, 32'd0);
    reset = 1'b0;
    tick();

    // Reset in the middle of a run.
    d0 = done_cnt;
    bus.go = 1'b1;
    bus.len = 8'd4;
    tick();
    bus.go = 1'b0;
    drive(1'b1, 32'h0001_0000);
    drive(1'b1, 32'h0002_0000);
    chk("mid_partial", bus.out, 32'h0003_0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_out",  bus.out, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_ovf",  {31'd0, bus.overflow}, 32'd0);
    tick();
    tick();
    chk("mid_rst_nodone", done_cnt - d0, 0);
    start(8'd1, 32'h0001_0000, 1'b0);
    chk("len1_busy", {31'd0, bus.busy}, 32'd1);
    drive(1'b1, 32'h0001_0000);
    expect_done("len1");

    // Basic signed sum: 1.0 + 0.5 - 1.0.
    start(8'd3, 32'h0000_8000, 1'b0);
    drive(1'b1, 32'h0001_0000);
    chk("basic_partial", bus.out, 32'h0001_0000);
    drive(1'b1, 32'h0000_8000);
    drive(1'b1, 32'hFFFF_0000);
    expect_done("basic");

    // Stall cycles carry garbage that must not be summed.
    start(8'd2, 32'd12, 1'b0);
    drive(1'b1, 32'd5);
    drive(1'b0, 32'hDEAD_BEEF);
    drive(1'b0, 32'h1234_5678);
    chk("stall_nodone", {31'd0, bus.done}, 32'd0);
    drive(1'b1, 32'd7);
    expect_done("stall");
    tick();
    chk("idle_hold_out", bus.out, 32'd12);

    // Zero length: in_valid pulses on the go cycle and the DONE cycle are ignored.
    sb.push_back('{res: 32'd0, ovf: 1'b0});
    bus.go = 1'b1;
    bus.len = 8'd0;
    bus.in_valid = 1'b1;
    bus.in = 32'h0000_1234;
    tick();
    bus.go = 1'b0;
    expect_done("zero");
    bus.in_valid = 1'b0;
    chk("zero_hold_out", bus.out, 32'd0);

    // Positive saturation.
    start(8'd2, 32'h7FFF_FFFF, 1'b1);
    drive(1'b1, 32'h7FFF_FFFF);
    chk("satp_pre_ovf", {31'd0, bus.overflow}, 32'd0);
    drive(1'b1, 32'h0000_0001);
    expect_done("satp");

    // Negative saturation. The flag is sticky in IDLE and clears on the next go.
    start(8'd2, 32'h8000_0000, 1'b1);
    drive(1'b1, 32'h8000_0000);
    chk("satn_pre_ovf", {31'd0, bus.overflow}, 32'd0);
    drive(1'b1, 32'hFFFF_FFFF);
    expect_done("satn");
    tick();
    chk("ovf_sticky", {31'd0, bus.overflow}, 32'd1);

    // go held high through a whole run yields a single run. The restart comes only from IDLE.
    d0 = done_cnt;
    sb.push_back('{res: 32'd6, ovf: 1'b0});
    bus.go = 1'b1;
    bus.len = 8'd3;
    tick();
    chk("go_clr_ovf", {31'd0, bus.overflow}, 32'd0);
    chk("go_clr_out", bus.out, 32'd0);
    drive(1'b1, 32'd1);
    drive(1'b1, 32'd2);
    drive(1'b1, 32'd3);
    chk("held_done", {31'd0, bus.done}, 32'd1);
    chk("held_out",  bus.out, 32'd6);
    void'(sb.pop_front());
    tick();
    chk("held_gap_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    chk("held_restart_busy", {31'd0, bus.busy}, 32'd1);
    chk("held_single_done", done_cnt - d0, 1);
    bus.go = 1'b0;
    sb.push_back('{res: 32'd30, ovf: 1'b0});
    drive(1'b1, 32'd10);
    drive(1'b1, 32'd10);
    drive(1'b1, 32'd10);
    expect_done("restart");
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound on total runtime. It reaches the summary line even if the stimulus stalls.
  initial begin
    #20000;
    failures++;
    $display("FAIL timeout got=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_fp_accum.md
Name: pipelined_fp_accum

Overview:
- Signed fixed-point accumulator that sits directly downstream of the pipelined fixed-point multiplier.
- Consumes a stream of products tagged by in_valid and sums a programmed number of them with saturation.
- Reports the result with a go/done handshake; together with the multiplier it forms the dot-product datapath.
- The producer aligns in_valid to the multiplier's fixed 4-cycle latency; this block imposes no latency of its own on inputs.

Parameters:
- WIDTH, 32, bit width of products and result (signed two's complement).
- INT_WIDTH, 16, integer bits of the fixed-point format (informational; arithmetic is format-agnostic).
- FRAC_WIDTH, 16, fractional bits; WIDTH = INT_WIDTH + FRAC_WIDTH.
- CNT_WIDTH, 8, width of the length and element counter.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- go  input  1  start request; sampled only in IDLE.
- len  input  CNT_WIDTH  number of valid products to sum; sampled with go.
- in  input  WIDTH  product from multiplier (signed).
- in_valid  input  1  in carries a product to accumulate this cycle.
- out  output  WIDTH  accumulated result (signed).
- done  output  1  one-cycle pulse: out holds final result.
- busy  output  1  high in ACC and DONE states.
- overflow  output  1  sticky: saturation occurred during current/last run.

Behaviour:
- Reset (synchronous, active-high): state <= IDLE; acc, count, len_q <= 0; out = 0, done = 0, busy = 0, overflow = 0. Reset asserted mid-run aborts the run with no done pulse; reset has priority over every other input.
- States: IDLE, ACC, DONE.
- IDLE:
  - go=1 latches len into len_q and clears acc, count and overflow.
  - If len==0: next state DONE, out=0.
  - Else: next state ACC.
  - in_valid is ignored in IDLE.
- ACC:
  - Each cycle with in_valid=1: acc <= sat(acc + in); count <= count+1.
  - If count==len_q-1 on that accepted sample: next state DONE.
  - in_valid=0 cycles are stalls; no state change.
  - go is ignored.
- DONE:
  - done=1 for exactly one cycle, out = final acc.
  - Next state IDLE unconditionally; in_valid and go are ignored this cycle.
  - A go in the following IDLE cycle starts a new run, so back-to-back runs have a 1-cycle gap minimum.
- Latency: done rises the cycle after the last valid product is sampled.
- out: driven from acc register at all times. It holds its value through IDLE until the next accepted go clears it, and it is visible mid-run as a partial sum.
- Saturating add: compute the (WIDTH+1)-bit signed sum.
  - Above 2^(WIDTH-1)-1: clamp to max and set overflow.
  - Below -2^(WIDTH-1): clamp to min and set overflow.
  - overflow is sticky until the next accepted go or reset.
  - Accumulation continues from the clamped value.
- Counter: count never wraps. len_q max is 2^CNT_WIDTH-1, and termination occurs at len_q-1, before count can overflow.
- busy = (state != IDLE).

Test Plan:
- Reset mid-run: go, len=4, two valid samples, then reset for 1 cycle -> no done pulse, out=0, busy=0, overflow=0; next go, len=1, in=0x00010000 -> done after 1 sample, out=0x00010000.
- Basic sum: go, len=3; valid in = 0x00010000 (1.0), 0x00008000 (0.5), 0xFFFF0000 (-1.0) on consecutive cycles -> done the cycle after the third sample, out=0x00008000, overflow=0.
- Stalls: len=2; in_valid pattern 1,0,0,1 with in=5, X, X, 7 -> X values are ignored; done one cycle after the 4th cycle, out=12.
- Zero length: go, len=0 -> DONE next cycle, done=1, out=0; in_valid pulses during that time are ignored.
- Saturation positive: len=2, in=0x7FFFFFFF, then 0x00000001 -> out=0x7FFFFFFF, overflow=1.
- Saturation negative and clear: len=2, in=0x80000000, then 0xFFFFFFFF -> out=0x80000000, overflow=1. Next go clears overflow to 0 in the same cycle the run starts.
- Ignored go: go held high throughout an ACC run of len=3 -> a single run, a single done pulse; a new run starts only from the IDLE cycle after DONE.
